// File: rtl/tdc_interval_multi.sv
// Multi-channel start/stop interval TDC with synchronisers, timeout and
// round-robin serialisation of results onto one valid/ready port.
//
// Ports:
//   clk, reset (async, active-high): clock and reset
//   enable                : lets idle channels arm on a start edge
//   start, stop [N_CH]    : asynchronous per-channel events
//   busy [N_CH]           : channel is RUN or DONE
//   o_valid/i_ready       : result handshake
//   o_chan, o_count       : channel index and interval of the result
//   o_timeout             : result ended by TIMEOUT rather than stop
//   o_drop [8] (only with TDC_DROP_COUNT_EN): saturating count of start
//     edges ignored because their channel was RUN or DONE
module tdc_interval_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  stop,
  output logic [N_CH-1:0]  busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CW-1:0]    o_chan,
  output logic [CNT_W-1:0] o_count,
  output logic             o_timeout
`ifdef TDC_DROP_COUNT_EN
  ,
  output logic [7:0]       o_drop
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [CW:0]      NCH_W = (CW+1)'(N_CH);
  localparam logic [CW-1:0]    LAST  = CW'(N_CH - 1);

  logic [N_CH-1:0]  start_sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  start_sync_d [SYNC_STAGES];
  logic [N_CH-1:0]  stop_sync_q  [SYNC_STAGES];
  logic [N_CH-1:0]  stop_sync_d  [SYNC_STAGES];
  logic [N_CH-1:0]  start_prev_q, start_prev_d;
  logic [N_CH-1:0]  stop_prev_q, stop_prev_d;
  logic [N_CH-1:0]  start_edge_q, start_edge_d;
  logic [N_CH-1:0]  stop_edge_q, stop_edge_d;

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  tmo_q, tmo_d;

  logic [CW-1:0]    ptr_q, ptr_d;
  logic             o_valid_q, o_valid_d;
  logic [CW-1:0]    o_chan_q, o_chan_d;
  logic [CNT_W-1:0] o_count_q, o_count_d;
  logic             o_timeout_q, o_timeout_d;

  logic [N_CH-1:0]  done_mask;
  logic [N_CH-1:0]  grant;
  logic [CW-1:0]    gidx;
  logic [CW:0]      rr_sum;
  logic             any_done;
  logic             take;
  logic             load;

  // Synchroniser chain plus registered rising-edge detect.
  always_comb begin
    start_sync_d[0] = start;
    stop_sync_d[0]  = stop;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      start_sync_d[s] = start_sync_q[s-1];
      stop_sync_d[s]  = stop_sync_q[s-1];
    end
    start_prev_d = start_sync_q[SYNC_STAGES-1];
    stop_prev_d  = stop_sync_q[SYNC_STAGES-1];
    start_edge_d = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
    stop_edge_d  = stop_sync_q[SYNC_STAGES-1] & ~stop_prev_q;
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      busy[c]      = (state_q[c] != S_IDLE);
      done_mask[c] = (state_q[c] == S_DONE);
    end
  end

  // Round-robin search over DONE channels starting at ptr_q.
  always_comb begin
    any_done = 1'b0;
    gidx     = ptr_q;
    rr_sum   = '0;
    for (int i = 0; i < N_CH; i++) begin
      rr_sum = {1'b0, ptr_q} + (CW+1)'(i);
      if (rr_sum >= NCH_W) rr_sum = rr_sum - NCH_W;
      if (!any_done && done_mask[rr_sum[CW-1:0]]) begin
        any_done = 1'b1;
        gidx     = rr_sum[CW-1:0];
      end
    end
  end

  always_comb begin
    take        = ~o_valid_q | i_ready;
    load        = take & any_done;
    grant       = load ? (N_CH'(1) << gidx) : '0;
    o_valid_d   = take ? any_done : o_valid_q;
    o_chan_d    = load ? gidx : o_chan_q;
    o_count_d   = load ? cnt_q[gidx] : o_count_q;
    o_timeout_d = load ? tmo_q[gidx] : o_timeout_q;
    ptr_d       = ptr_q;
    if (load) ptr_d = (gidx == LAST) ? '0 : gidx + CW'(1);
  end

  // cnt counts cycles since the start edge, so arming loads 1 and the
  // value held at the stop cycle is already the interval.
  always_comb begin
    tmo_d = tmo_q;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      unique case (state_q[c])
        S_IDLE: begin
          if (start_edge_q[c] & enable & ~stop_edge_q[c]) begin
            state_d[c] = S_RUN;
            cnt_d[c]   = CNT_W'(1);
            tmo_d[c]   = 1'b0;
          end
        end
        S_RUN: begin
          if (stop_edge_q[c]) begin
            state_d[c] = S_DONE;
            tmo_d[c]   = 1'b0;
          end else if (cnt_q[c] == TMO) begin
            state_d[c] = S_DONE;
            tmo_d[c]   = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (grant[c]) begin
            state_d[c] = S_IDLE;
            cnt_d[c]   = '0;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        start_sync_q[s] <= '0;
        stop_sync_q[s]  <= '0;
      end
      start_prev_q <= '0;
      stop_prev_q  <= '0;
      start_edge_q <= '0;
      stop_edge_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
      end
      tmo_q       <= '0;
      ptr_q       <= '0;
      o_valid_q   <= 1'b0;
      o_chan_q    <= '0;
      o_count_q   <= '0;
      o_timeout_q <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        start_sync_q[s] <= start_sync_d[s];
        stop_sync_q[s]  <= stop_sync_d[s];
      end
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      start_edge_q <= start_edge_d;
      stop_edge_q  <= stop_edge_d;
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      tmo_q       <= tmo_d;
      ptr_q       <= ptr_d;
      o_valid_q   <= o_valid_d;
      o_chan_q    <= o_chan_d;
      o_count_q   <= o_count_d;
      o_timeout_q <= o_timeout_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_chan    = o_chan_q;
  assign o_count   = o_count_q;
  assign o_timeout = o_timeout_q;

`ifdef TDC_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;

  // Start edges landing on a busy channel are dropped; several may
  // land in one cycle, so add them all before saturating.
  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int c = 0; c < N_CH; c++)
      drop_sum = drop_sum + 9'(start_edge_q[c] & busy[c]);
    drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign o_drop = drop_q;
`endif

endmodule

// File: tb/tb_tdc_interval_multi.sv
// Bench for tdc_interval_multi: directed scenarios plus randomized
// per-channel intervals checked against an interval/timeout model.
module tb_tdc_interval_multi;

  localparam int N = 4;
  localparam int W = 16;
  localparam int T = 20;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] start;
  logic [N-1:0] stop;
  logic [N-1:0] busy;
  logic         o_valid;
  logic         i_ready;
  logic [1:0]   o_chan;
  logic [W-1:0] o_count;
  logic         o_timeout;
`ifdef TDC_DROP_COUNT_EN
  logic [7:0]   o_drop;
`endif

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ptr_exp = 0;
  int drop_exp = 0;

  tdc_interval_multi #(
    .N_CH(N), .CNT_W(W), .TIMEOUT(T), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start(start), .stop(stop), .busy(busy),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_chan(o_chan), .o_count(o_count), .o_timeout(o_timeout)
`ifdef TDC_DROP_COUNT_EN
    , .o_drop(o_drop)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_valid(input int lim, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (o_valid) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic quiesce();
    start = '0;
    stop  = '0;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    start   = '0;
    stop    = '0;
    ptr_exp = 0;
    drop_exp = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    i_ready = 1'b1;
    start   = '0;
    stop    = '0;
    repeat (3) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    checks++; if (o_chan !== 2'd0) begin errors++;
      $display("FAIL reset_chan got=%0d exp=0", o_chan); end
    checks++; if (o_count !== 16'd0) begin errors++;
      $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_timeout !== 1'b0) begin errors++;
      $display("FAIL reset_timeout got=%0b exp=0", o_timeout); end
    checks++; if (busy !== 4'b0) begin errors++;
      $display("FAIL reset_busy got=%b exp=0000", busy); end
`ifdef TDC_DROP_COUNT_EN
    checks++; if (o_drop !== 8'd0) begin errors++;
      $display("FAIL reset_drop got=%0d exp=0", o_drop); end
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    int at;
    bit ok;
    int p0;
    i_ready = 1'b0;
    start = '1;
    repeat (7) @(negedge clk);
    stop = '1;
    wait_valid(40, at, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL stall_valid got=timeout exp=valid"); end
    p0 = ptr_exp;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_chan !== 2'(p0) ||
          o_count !== 16'd7 || o_timeout !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold k=%0d got v=%0b ch=%0d cnt=%0d to=%0b exp v=1 ch=%0d cnt=7 to=0",
                 k, o_valid, o_chan, o_count, o_timeout, p0);
      end
      @(negedge clk);
    end
    i_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_chan !== 2'((p0 + k) % N) ||
          o_count !== 16'd7 || o_timeout !== 1'b0) begin
        errors++;
        $display("FAIL stall_drain k=%0d got v=%0b ch=%0d cnt=%0d exp v=1 ch=%0d cnt=7",
                 k, o_valid, o_chan, o_count, (p0 + k) % N);
      end
      @(negedge clk);
    end
    ptr_exp = p0;
    checks++; if (o_valid !== 1'b0 || busy !== 4'b0) begin errors++;
      $display("FAIL stall_after got v=%0b busy=%b exp v=0 busy=0000", o_valid, busy); end
    quiesce();
  endtask

  task automatic test_basic();
    int n0, n1, at;
    bit ok;
    i_ready = 1'b1;
    start[0] = 1'b1;
    n0 = cyc;
    repeat (10) @(negedge clk);
    stop[0] = 1'b1;
    n1 = cyc;
    wait_valid(40, at, ok);
    checks++; if (!ok || at != n1 + S + 3) begin errors++;
      $display("FAIL basic_latency got=%0d exp=%0d", at - n1, S + 3); end
    checks++;
    if (o_chan !== 2'd0 || o_count !== 16'(n1 - n0) || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got ch=%0d cnt=%0d to=%0b exp ch=0 cnt=%0d to=0",
               o_chan, o_count, o_timeout, n1 - n0);
    end
    ptr_exp = 1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || busy[0] !== 1'b0) begin errors++;
      $display("FAIL basic_after got v=%0b busy0=%0b exp 0 0", o_valid, busy[0]); end
    quiesce();
  endtask

  task automatic test_timeout();
    int n0, at;
    bit ok;
    start[1] = 1'b1;
    n0 = cyc;
    wait_valid(60, at, ok);
    checks++; if (!ok || at != n0 + S + T + 3) begin errors++;
      $display("FAIL timeout_latency got=%0d exp=%0d", at - n0, S + T + 3); end
    checks++;
    if (o_chan !== 2'd1 || o_count !== 16'(T) || o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result got ch=%0d cnt=%0d to=%0b exp ch=1 cnt=%0d to=1",
               o_chan, o_count, o_timeout, T);
    end
    ptr_exp = 2;
    quiesce();
  endtask

  task automatic test_simul_and_drop();
    int at;
    bit ok;
    bit seen;
    seen = 1'b0;
    start[2] = 1'b1;
    stop[2]  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    checks++; if (seen || busy[2] !== 1'b0) begin errors++;
      $display("FAIL simul_idle got seen=%0b busy2=%0b exp 0 0", seen, busy[2]); end
    quiesce();
    start[0] = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    drop_exp++;
    repeat (7) @(negedge clk);
    stop[0] = 1'b1;
    wait_valid(40, at, ok);
    checks++;
    if (!ok || o_chan !== 2'd0 || o_count !== 16'd12 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL extra_start got ok=%0b ch=%0d cnt=%0d to=%0b exp ch=0 cnt=12 to=0",
               ok, o_chan, o_count, o_timeout);
    end
    ptr_exp = 1;
`ifdef TDC_DROP_COUNT_EN
    checks++; if (o_drop !== 8'(drop_exp)) begin errors++;
      $display("FAIL drop_count got=%0d exp=%0d", o_drop, drop_exp); end
`endif
    quiesce();
  endtask

  task automatic test_enable();
    int at;
    bit ok;
    bit seen;
    seen = 1'b0;
    enable = 1'b0;
    start[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    checks++; if (seen || busy !== 4'b0) begin errors++;
      $display("FAIL enable_block got seen=%0b busy=%b exp 0 0000", seen, busy); end
    quiesce();
    enable = 1'b1;
    start[0] = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    stop[0] = 1'b1;
    wait_valid(40, at, ok);
    checks++;
    if (!ok || o_chan !== 2'd0 || o_count !== 16'd8 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop got ok=%0b ch=%0d cnt=%0d to=%0b exp ch=0 cnt=8 to=0",
               ok, o_chan, o_count, o_timeout);
    end
    ptr_exp = 1;
    enable = 1'b1;
    quiesce();
  endtask

  task automatic test_reset_mid();
    int at;
    bit ok;
    i_ready = 1'b0;
    start[0] = 1'b1;
    start[1] = 1'b1;
    repeat (3) @(negedge clk);
    stop[1] = 1'b1;
    wait_valid(40, at, ok);
    checks++; if (!ok || busy[0] !== 1'b1) begin errors++;
      $display("FAIL mid_setup got ok=%0b busy0=%0b exp 1 1", ok, busy[0]); end
    #2 reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || busy !== 4'b0) begin errors++;
      $display("FAIL mid_async got v=%0b busy=%b exp 0 0000", o_valid, busy); end
    start = '0;
    stop  = '0;
    i_ready = 1'b1;
    ptr_exp = 0;
    drop_exp = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (S + 3) @(negedge clk);
    start[0] = 1'b1;
    repeat (5) @(negedge clk);
    stop[0] = 1'b1;
    wait_valid(40, at, ok);
    checks++;
    if (!ok || o_chan !== 2'd0 || o_count !== 16'd5 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got ok=%0b ch=%0d cnt=%0d to=%0b exp ch=0 cnt=5 to=0",
               ok, o_chan, o_count, o_timeout);
    end
    ptr_exp = 1;
    quiesce();
  endtask

  task automatic test_random();
    int st [N];
    int dur [N];
    bit hs [N];
    int ecnt [N];
    bit etmo [N];
    bit got [N];
    int nrecv;
    int t;
    int c;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < N; k++) begin
        st[k]  = $urandom_range(0, 4);
        dur[k] = $urandom_range(1, 26);
        hs[k]  = ($urandom_range(0, 3) != 0);
        got[k] = 1'b0;
        if (hs[k] && dur[k] <= T) begin
          ecnt[k] = dur[k];
          etmo[k] = 1'b0;
        end else begin
          ecnt[k] = T;
          etmo[k] = 1'b1;
        end
      end
      nrecv = 0;
      t = 0;
      while (t < 250) begin
        for (int k = 0; k < N; k++) begin
          if (t == st[k]) start[k] = 1'b1;
          if (hs[k] && t == st[k] + dur[k]) stop[k] = 1'b1;
        end
        i_ready = ($urandom_range(0, 3) != 0);
        if (o_valid && i_ready) begin
          c = int'(o_chan);
          checks++;
          if (got[c]) begin
            errors++;
            $display("FAIL rand_dup it=%0d ch=%0d got=dup exp=single", it, c);
          end else if (o_count !== 16'(ecnt[c]) || o_timeout !== etmo[c]) begin
            errors++;
            $display("FAIL rand_result it=%0d ch=%0d got cnt=%0d to=%0b exp cnt=%0d to=%0b",
                     it, c, o_count, o_timeout, ecnt[c], etmo[c]);
          end
          got[c] = 1'b1;
          nrecv++;
          ptr_exp = (c + 1) % N;
        end
        if (nrecv >= N && t >= 35) break;
        @(negedge clk);
        t++;
      end
      checks++; if (nrecv != N) begin errors++;
        $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, nrecv, N); end
      i_ready = 1'b1;
      quiesce();
      checks++; if (busy !== 4'b0 || o_valid !== 1'b0) begin errors++;
        $display("FAIL rand_idle it=%0d got busy=%b v=%0b exp 0000 0", it, busy, o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_basic();
    test_timeout();
    test_simul_and_drop();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
